// File: rtl/oitf_scb_if.sv
// Dispatch/retire bundle between the long-instruction dispatcher (master) and the
// outstanding-instruction scoreboard (slave).
`ifndef MYRISCV_REGADDRBUS
`define MYRISCV_REGADDRBUS 4:0
`endif

interface oitf_scb_if #(
    parameter int CW = 3
);
    logic                       dis_vld;
    logic                       dis_rdy;
    logic                       dis_rdwen;
    logic [`MYRISCV_REGADDRBUS] dis_rdidx;
    logic                       dis_rs1en;
    logic                       dis_rs2en;
    logic [`MYRISCV_REGADDRBUS] dis_rs1idx;
    logic [`MYRISCV_REGADDRBUS] dis_rs2idx;
    logic                       clr_req;
    logic [`MYRISCV_REGADDRBUS] clr_idx;
    logic                       oitf_raw_dep;
    logic                       oitf_waw_dep;
    logic                       oitf_empty;
    logic [CW-1:0]              oitf_cnt;
    logic                       clr_err;

    modport master (
        output dis_vld, dis_rdwen, dis_rdidx, dis_rs1en, dis_rs2en,
               dis_rs1idx, dis_rs2idx, clr_req, clr_idx,
        input  dis_rdy, oitf_raw_dep, oitf_waw_dep, oitf_empty, oitf_cnt, clr_err
    );

    modport slave (
        input  dis_vld, dis_rdwen, dis_rdidx, dis_rs1en, dis_rs2en,
               dis_rs1idx, dis_rs2idx, clr_req, clr_idx,
        output dis_rdy, oitf_raw_dep, oitf_waw_dep, oitf_empty, oitf_cnt, clr_err
    );
endinterface

// File: rtl/oitf_scb.sv
// Outstanding long-instruction scoreboard: per-register pending counters with RAW/WAW hazard flags.
// Define MYRISCV_OITF_CLR_BYPASS_EN to let a same-cycle retire mask the hazard it resolves.
`ifndef MYRISCV_REGADDRBUS
`define MYRISCV_REGADDRBUS 4:0
`endif

module oitf_scb #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic      clk,
    input  logic      rst,
    oitf_scb_if.slave bus
);
    localparam int            NREG     = 32;
    localparam int            AW       = 5;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_ONE   = CW'(1);

    logic [CW-1:0] r_pend [NREG];
    logic [CW-1:0] r_total;
    logic          r_clr_err;

    logic          w_rdy;
    logic          w_alloc;
    logic          w_clr_hit;
    logic          w_clr_ok;
    logic          w_clr_bad;
    logic          w_same;
    logic [CW-1:0] w_eff [NREG];

    assign w_rdy     = (r_total != LP_DEPTH);
    assign w_alloc   = bus.dis_vld & w_rdy & bus.dis_rdwen;
    assign w_clr_hit = (r_pend[bus.clr_idx] != '0);
    assign w_clr_ok  = bus.clr_req & w_clr_hit;
    assign w_clr_bad = bus.clr_req & ~w_clr_hit;
    // Allocate and retire on the same register cancel out.
    assign w_same    = w_alloc & w_clr_ok & (bus.dis_rdidx == bus.clr_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
            r_total   <= '0;
            r_clr_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (!w_same) begin
                    if (w_alloc && (bus.dis_rdidx == AW'(i)))
                        r_pend[i] <= r_pend[i] + LP_ONE;
                    else if (w_clr_ok && (bus.clr_idx == AW'(i)))
                        r_pend[i] <= r_pend[i] - LP_ONE;
                end
            end
            if (w_alloc && !w_clr_ok)
                r_total <= r_total + LP_ONE;
            else if (w_clr_ok && !w_alloc)
                r_total <= r_total - LP_ONE;
            r_clr_err <= r_clr_err | w_clr_bad;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
`ifdef MYRISCV_OITF_CLR_BYPASS_EN
            w_eff[i] = r_pend[i] - CW'(w_clr_ok && (bus.clr_idx == AW'(i)));
`else
            w_eff[i] = r_pend[i];
`endif
        end
    end

    // Register x0 is counted but never reported as a hazard.
    assign bus.oitf_raw_dep = (bus.dis_rs1en & (bus.dis_rs1idx != '0) & (w_eff[bus.dis_rs1idx] != '0))
                            | (bus.dis_rs2en & (bus.dis_rs2idx != '0) & (w_eff[bus.dis_rs2idx] != '0));
    assign bus.oitf_waw_dep = bus.dis_rdwen & (bus.dis_rdidx != '0) & (w_eff[bus.dis_rdidx] != '0);
    assign bus.dis_rdy      = w_rdy;
    assign bus.oitf_empty   = (r_total == '0);
    assign bus.oitf_cnt     = r_total;
    assign bus.clr_err      = r_clr_err;
endmodule

// File: tb/tb_oitf_scb.sv
// Directed table-driven bench for oitf_scb (DEPTH=4) plus an asynchronous mid-stream reset sequence.
module tb_oitf_scb;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef MYRISCV_OITF_CLR_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    oitf_scb_if #(.CW(CW)) bus ();

    oitf_scb #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic       rdwen;
        logic [4:0] rdidx;
        logic       rs1en;
        logic [4:0] rs1idx;
        logic       rs2en;
        logic [4:0] rs2idx;
        logic       clr;
        logic [4:0] clridx;
        int         e_rdy;
        int         e_raw;
        int         e_waw;
        int         e_empty;
        int         e_cnt;
        int         e_err;
    } vec_t;

    localparam int NV = 25;
    vec_t vt [NV];

    function automatic vec_t mk(input int vld, input int rdwen, input int rdidx,
                                input int rs1en, input int rs1idx, input int rs2en, input int rs2idx,
                                input int clr, input int clridx,
                                input int rdy, input int raw, input int waw,
                                input int empty, input int cnt, input int err);
        vec_t v;
        v.vld    = vld[0];
        v.rdwen  = rdwen[0];
        v.rdidx  = rdidx[4:0];
        v.rs1en  = rs1en[0];
        v.rs1idx = rs1idx[4:0];
        v.rs2en  = rs2en[0];
        v.rs2idx = rs2idx[4:0];
        v.clr    = clr[0];
        v.clridx = clridx[4:0];
        v.e_rdy  = rdy;
        v.e_raw  = raw;
        v.e_waw  = waw;
        v.e_empty = empty;
        v.e_cnt  = cnt;
        v.e_err  = err;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.dis_vld    = v.vld;
        bus.dis_rdwen  = v.rdwen;
        bus.dis_rdidx  = v.rdidx;
        bus.dis_rs1en  = v.rs1en;
        bus.dis_rs1idx = v.rs1idx;
        bus.dis_rs2en  = v.rs2en;
        bus.dis_rs2idx = v.rs2idx;
        bus.clr_req    = v.clr;
        bus.clr_idx    = v.clridx;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " dis_rdy"},      int'(bus.dis_rdy),      v.e_rdy);
        chk({tag, " oitf_raw_dep"}, int'(bus.oitf_raw_dep), v.e_raw);
        chk({tag, " oitf_waw_dep"}, int'(bus.oitf_waw_dep), v.e_waw);
        chk({tag, " oitf_empty"},   int'(bus.oitf_empty),   v.e_empty);
        chk({tag, " oitf_cnt"},     int'(bus.oitf_cnt),     v.e_cnt);
        chk({tag, " clr_err"},      int'(bus.clr_err),      v.e_err);
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        //               vld we rd s1e s1 s2e s2 clr ci | rdy raw waw emp cnt err
        vt[0]  = mk(1, 1, 5,  0, 0, 0, 0,  0, 0,   1, 0, 0, 1, 0, 0); // alloc rd5
        vt[1]  = mk(0, 0, 0,  1, 5, 0, 0,  0, 0,   1, 1, 0, 0, 1, 0); // RAW on x5
        vt[2]  = mk(0, 1, 5,  0, 0, 0, 0,  0, 0,   1, 0, 1, 0, 1, 0); // WAW on x5
        vt[3]  = mk(0, 0, 0,  0, 0, 0, 0,  1, 5,   1, 0, 0, 0, 1, 0); // retire x5
        vt[4]  = mk(0, 0, 0,  0, 0, 0, 0,  0, 0,   1, 0, 0, 1, 0, 0);
        vt[5]  = mk(1, 1, 1,  0, 0, 0, 0,  0, 0,   1, 0, 0, 1, 0, 0); // fill rd1..rd4
        vt[6]  = mk(1, 1, 2,  0, 0, 0, 0,  0, 0,   1, 0, 0, 0, 1, 0);
        vt[7]  = mk(1, 1, 3,  0, 0, 0, 0,  0, 0,   1, 0, 0, 0, 2, 0);
        vt[8]  = mk(1, 1, 4,  0, 0, 0, 0,  0, 0,   1, 0, 0, 0, 3, 0);
        vt[9]  = mk(1, 1, 6,  0, 0, 0, 0,  0, 0,   0, 0, 0, 0, 4, 0); // fifth, refused
        vt[10] = mk(0, 0, 0,  0, 0, 0, 0,  1, 2,   0, 0, 0, 0, 4, 0); // retire x2 while full
        vt[11] = mk(0, 1, 6,  1, 2, 0, 0,  0, 0,   1, 0, 0, 0, 3, 0); // x6 never counted
        vt[12] = mk(1, 1, 7,  0, 0, 0, 0,  1, 1,   1, 0, 0, 0, 3, 0); // alloc at DEPTH-1 + retire
        vt[13] = mk(0, 0, 0,  1, 1, 1, 7,  0, 0,   1, 1, 0, 0, 3, 0);
        vt[14] = mk(0, 0, 0,  1, 1, 0, 0,  0, 0,   1, 0, 0, 0, 3, 0);
        vt[15] = mk(1, 1, 7,  0, 0, 0, 0,  1, 7,   1, 0, 1 - BYP, 0, 3, 0); // same-reg alloc+retire
        vt[16] = mk(0, 1, 7,  0, 0, 0, 0,  0, 0,   1, 0, 1, 0, 3, 0);
        vt[17] = mk(0, 0, 0,  0, 0, 1, 3,  1, 3,   1, 1 - BYP, 0, 0, 3, 0); // retire x3, rs2=3
        vt[18] = mk(0, 0, 0,  0, 0, 1, 3,  0, 0,   1, 0, 0, 0, 2, 0);
        vt[19] = mk(0, 0, 0,  0, 0, 0, 0,  1, 9,   1, 0, 0, 0, 2, 0); // underflow on x9
        vt[20] = mk(0, 0, 0,  0, 0, 0, 0,  0, 0,   1, 0, 0, 0, 2, 1);
        vt[21] = mk(0, 0, 0,  0, 0, 0, 0,  1, 4,   1, 0, 0, 0, 2, 1);
        vt[22] = mk(0, 0, 0,  0, 0, 0, 0,  0, 0,   1, 0, 0, 0, 1, 1); // error is sticky
        vt[23] = mk(1, 1, 0,  1, 0, 0, 0,  0, 0,   1, 0, 0, 0, 1, 1); // alloc rd=x0
        vt[24] = mk(0, 1, 0,  1, 0, 0, 0,  0, 0,   1, 0, 0, 0, 2, 1);

        // Reset state, with a source lookup presented
        rst = 1'b0;
        v = mk(0, 1, 5, 1, 5, 1, 5, 0, 0, 1, 0, 0, 1, 0, 0);
        drive(v);
        #12;
        check_all("reset", v);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(vt[i]);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vt[i]);
        end

        // Asynchronous reset mid-cycle with x0 and x7 outstanding
        @(posedge clk);
        #1;
        v = mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 2, 1);
        drive(v);
        #1;
        check_all("pre_rst", v);
        #1;
        rst = 1'b0;
        #1;
        v = mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        check_all("async_rst", v);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        v = mk(0, 1, 7, 1, 7, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        drive(v);
        @(negedge clk);
        check_all("post_rst", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/oitf_scb.md
OITF_SCB -- requirements
Module: oitf_scb

Interface
REQ-001 SHALL have parameter: DEPTH, 4, maximum outstanding long instructions with a register write (power of two, 2..8).
REQ-002 SHALL have parameter: CW, $clog2(DEPTH)+1, width of the occupancy count and of each per-register pending count.
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: dis_vld  input  1  long-instruction dispatch valid; dis_rdy  output  1  dispatch may allocate.
REQ-006 SHALL have ports: dis_rdwen  input  1  instruction writes rd; dis_rdidx  input  `MYRISCV_REGADDRBUS  rd index.
REQ-007 SHALL have ports: dis_rs1en, dis_rs2en  input  1 each  source used; dis_rs1idx, dis_rs2idx  input  `MYRISCV_REGADDRBUS  source indices.
REQ-008 SHALL have ports: clr_req  input  1  writeback retire of a long instruction; clr_idx  input  `MYRISCV_REGADDRBUS  retired rd index.
REQ-009 SHALL have ports: oitf_raw_dep, oitf_waw_dep  output  1 each  hazard flags; oitf_empty  output  1  nothing outstanding.
REQ-010 SHALL have ports: oitf_cnt  output  CW  total outstanding; clr_err  output  1  sticky clear-underflow flag.

Function
REQ-011 SHALL hold one CW-bit pending counter per architectural register (32) plus a CW-bit total counter.
REQ-012 SHALL define alloc = dis_vld & dis_rdy & dis_rdwen; dispatch without dis_rdwen SHALL not allocate.
REQ-013 SHALL drive dis_rdy = (total != DEPTH), from registered state only; no same-cycle clear bypass to dis_rdy.
REQ-014 SHALL, on alloc, increment pend[dis_rdidx] and total at the next rising clk edge (1-cycle latency).
REQ-015 SHALL, on clr_req with pend[clr_idx] != 0, decrement pend[clr_idx] and total at the next edge.
REQ-016 SHALL, on clr_req with pend[clr_idx] == 0, leave all counters unchanged and set clr_err, which holds until reset.
REQ-017 SHALL, on alloc and valid clr_req in the same cycle, leave total unchanged; if dis_rdidx == clr_idx, leave that pend unchanged; else increment one and decrement the other.
REQ-018 SHALL accept alloc when total == DEPTH-1 and clr_req coincide; total then remains DEPTH-1.
REQ-019 SHALL track index 0 in counters and total, but never flag a hazard on index 0.
REQ-020 SHALL drive oitf_raw_dep = (rs1en & rs1idx!=0 & eff[rs1idx]!=0) | (rs2en & rs2idx!=0 & eff[rs2idx]!=0), combinationally.
REQ-021 SHALL drive oitf_waw_dep = dis_rdwen & dis_rdidx!=0 & eff[dis_rdidx]!=0, combinationally.
REQ-022 SHALL drive oitf_empty = (total == 0) and oitf_cnt = total.
REQ-023 SHALL gate nothing on hazards internally; the dispatcher withholds dis_vld while a hazard is flagged.

Reset
REQ-024 SHALL, while rst is low, asynchronously clear all pend counters, total and clr_err.
REQ-025 SHALL, in reset, output dis_rdy=1, oitf_empty=1, oitf_cnt=0, clr_err=0, and both dep flags 0.
REQ-026 SHALL discard outstanding entries when reset asserts mid-operation; no clear is expected afterwards.

Configuration
REQ-027 SHALL use macro MYRISCV_OITF_CLR_BYPASS_EN.
REQ-028 SHALL, with the macro defined, set eff[i] = pend[i] - (clr_req & clr_idx==i & pend[i]!=0), so a same-cycle retire removes the hazard.
REQ-029 SHALL, with the macro undefined, set eff[i] = pend[i]; hazards clear one cycle after retire.

Verification
REQ-030 SHALL check: reset, then alloc rd=5 -> next cycle oitf_cnt=1, oitf_empty=0; rs1=5 with rs1en -> oitf_raw_dep=1.
REQ-031 SHALL check: DEPTH=4, four allocs rd=1,2,3,4 -> dis_rdy=0; fifth dis_vld is not counted; clr_idx=2 -> next cycle dis_rdy=1, oitf_cnt=3.
REQ-032 SHALL check: pend[7]=1 and alloc rd=7 with clr_req idx=7 in the same cycle -> pend[7]=1, oitf_cnt unchanged, oitf_waw_dep stays 1.
REQ-033 SHALL check: clr_req idx=9 while pend[9]=0 -> clr_err=1 sticky, oitf_cnt unchanged; cleared only by rst low.
REQ-034 SHALL check: pend[3]=1, clr_req idx=3 with rs2=3 in the same cycle -> oitf_raw_dep=0 with the macro, 1 without.
REQ-035 SHALL check: allocs rd=0 and rs1=0 -> oitf_cnt=1 and oitf_raw_dep=0; rst low mid-stream -> all counters 0 asynchronously.
